// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp codes for the intersection controller.
package traffic_pkg;

    typedef enum logic [3:0] {
        NS_G    = 4'd0,
        NS_Y    = 4'd1,
        AR_NS   = 4'd2,
        WALK_NS = 4'd3,
        EW_G    = 4'd4,
        EW_Y    = 4'd5,
        AR_EW   = 4'd6,
        WALK_EW = 4'd7,
        FLASH   = 4'd8
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

endpackage

// File: rtl/dwell_timer.sv
// Down-counter for state dwell: loads a value, counts to zero, flags done at zero.
module dwell_timer #(
    parameter int CNT_W   = 8,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CNT_W'(RST_VAL);
        end else if (i_en) begin
            if (i_load) begin
                r_cnt <= i_load_val;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection controller with pedestrian walk phases and a flashing fail-safe mode.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 10,
    parameter int FLASH_CYC  = 8,
    parameter int CNT_W      = 8
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ped_req,
    input  logic       flash_req,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic       walk,
    output logic       ped_wait,
    output logic [3:0] phase
);

    localparam int MAX_DWELL = (1 << CNT_W) - 1;

    if (GREEN_CYC < 1 || GREEN_CYC > MAX_DWELL || YELLOW_CYC < 1 || YELLOW_CYC > MAX_DWELL ||
        ALLRED_CYC < 1 || ALLRED_CYC > MAX_DWELL || WALK_CYC < 1 || WALK_CYC > MAX_DWELL ||
        FLASH_CYC < 1 || FLASH_CYC > MAX_DWELL) begin : g_bad_dwell
        $error("dwell parameter outside 1..2^CNT_W-1");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic             r_blink;
    logic             w_blink_next;
    logic             r_ped_pending;
    logic             w_ped_next;
    logic             w_enter_walk;
    logic             w_done;
    logic [CNT_W-1:0] w_load_val;

    function automatic logic [CNT_W-1:0] dwell_of(input state_t s);
        case (s)
            NS_G, EW_G:       return CNT_W'(GREEN_CYC - 1);
            NS_Y, EW_Y:       return CNT_W'(YELLOW_CYC - 1);
            WALK_NS, WALK_EW: return CNT_W'(WALK_CYC - 1);
            FLASH:            return CNT_W'(FLASH_CYC - 1);
            default:          return CNT_W'(ALLRED_CYC - 1);
        endcase
    endfunction

    // Every expiry reloads the timer: either for the next state or the next flash half-period.
    dwell_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(ALLRED_CYC - 1)
    ) u_dwell_timer (
        .clk       (clock),
        .rst_n     (rst_n),
        .i_en      (enable),
        .i_load    (w_done),
        .i_load_val(w_load_val),
        .o_done    (w_done)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= AR_EW;
            r_blink       <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_blink       <= w_blink_next;
            r_ped_pending <= w_ped_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_blink_next = r_blink;
        w_enter_walk = 1'b0;
        if (enable && w_done) begin
            case (r_state)
                NS_G:    w_next_state = NS_Y;
                NS_Y:    w_next_state = AR_NS;
                AR_NS: begin
                    if (flash_req) begin
                        w_next_state = FLASH;
                        w_blink_next = 1'b1;
                    end else if (r_ped_pending) begin
                        w_next_state = WALK_NS;
                        w_enter_walk = 1'b1;
                    end else begin
                        w_next_state = EW_G;
                    end
                end
                WALK_NS: w_next_state = EW_G;
                EW_G:    w_next_state = EW_Y;
                EW_Y:    w_next_state = AR_EW;
                AR_EW: begin
                    if (flash_req) begin
                        w_next_state = FLASH;
                        w_blink_next = 1'b1;
                    end else if (r_ped_pending) begin
                        w_next_state = WALK_EW;
                        w_enter_walk = 1'b1;
                    end else begin
                        w_next_state = NS_G;
                    end
                end
                WALK_EW: w_next_state = NS_G;
                FLASH: begin
                    if (!flash_req) begin
                        w_next_state = AR_EW;
                        w_blink_next = 1'b0;
                    end else begin
                        w_blink_next = ~r_blink;
                    end
                end
                default: w_next_state = AR_EW;
            endcase
        end
        w_load_val = dwell_of(w_next_state);
        w_ped_next = (r_ped_pending | ped_req) & ~w_enter_walk;
    end

    always_comb begin
        light_ns = RED;
        light_ew = RED;
        walk     = 1'b0;
        case (r_state)
            NS_G:             light_ns = GREEN;
            NS_Y:             light_ns = YELLOW;
            EW_G:             light_ew = GREEN;
            EW_Y:             light_ew = YELLOW;
            WALK_NS, WALK_EW: walk = 1'b1;
            FLASH: begin
                light_ns = r_blink ? YELLOW : DARK;
                light_ew = r_blink ? RED : DARK;
            end
            default: ;
        endcase
    end

    assign ped_wait = r_ped_pending;
    assign phase    = r_state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench: spec-derived sequences, a cycle-level reference model under random stimulus, and a short-dwell parameter table.
module tb_traffic_intersection_ctrl;
    import traffic_pkg::*;

    localparam int G = 20, Y = 4, AR = 2, WK = 10, FL = 8;

    logic       clock = 1'b0;
    logic       rst_n, enable, ped_req, flash_req;
    logic [2:0] light_ns, light_ew;
    logic       walk, ped_wait;
    logic [3:0] phase;

    logic       rst2_n, en2;
    logic [2:0] ns2, ew2;
    logic       walk2, pw2;
    logic [3:0] ph2;

    always #5 clock = ~clock;

    traffic_intersection_ctrl #(
        .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(AR), .WALK_CYC(WK), .FLASH_CYC(FL), .CNT_W(8)
    ) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable), .ped_req(ped_req), .flash_req(flash_req),
        .light_ns(light_ns), .light_ew(light_ew), .walk(walk), .ped_wait(ped_wait), .phase(phase)
    );

    traffic_intersection_ctrl #(
        .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1), .WALK_CYC(WK), .FLASH_CYC(FL), .CNT_W(8)
    ) dut2 (
        .clock(clock), .rst_n(rst2_n), .enable(en2), .ped_req(1'b0), .flash_req(1'b0),
        .light_ns(ns2), .light_ew(ew2), .walk(walk2), .ped_wait(pw2), .phase(ph2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase name plus enabled cycles left in the current dwell (counts down to 1).
    state_t m_st;
    int     m_left;
    bit     m_blink, m_pend;

    function automatic int dwell(input state_t s);
        case (s)
            NS_G, EW_G:       return G;
            NS_Y, EW_Y:       return Y;
            WALK_NS, WALK_EW: return WK;
            FLASH:            return FL;
            default:          return AR;
        endcase
    endfunction

    task automatic m_reset();
        m_st = AR_EW; m_left = AR; m_blink = 1'b0; m_pend = 1'b0;
    endtask

    task automatic m_step(input bit en, input bit ped, input bit fl);
        state_t nx;
        bit     entered;
        entered = 1'b0;
        if (en) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                nx = m_st;
                case (m_st)
                    NS_G:    nx = NS_Y;
                    NS_Y:    nx = AR_NS;
                    AR_NS:   nx = fl ? FLASH : (m_pend ? WALK_NS : EW_G);
                    WALK_NS: nx = EW_G;
                    EW_G:    nx = EW_Y;
                    EW_Y:    nx = AR_EW;
                    AR_EW:   nx = fl ? FLASH : (m_pend ? WALK_EW : NS_G);
                    WALK_EW: nx = NS_G;
                    FLASH:   nx = fl ? FLASH : AR_EW;
                    default: nx = AR_EW;
                endcase
                if (nx == FLASH) m_blink = (m_st == FLASH) ? !m_blink : 1'b1;
                else             m_blink = 1'b0;
                entered = (nx == WALK_NS) || (nx == WALK_EW);
                m_st    = nx;
                m_left  = dwell(nx);
            end
        end
        m_pend = (m_pend | ped) & !entered;
    endtask

    function automatic logic [7:0] m_out();
        logic [2:0] ns, ew;
        logic       w;
        ns = 3'b100; ew = 3'b100; w = 1'b0;
        case (m_st)
            NS_G:             ns = 3'b010;
            NS_Y:             ns = 3'b001;
            EW_G:             ew = 3'b010;
            EW_Y:             ew = 3'b001;
            WALK_NS, WALK_EW: w = 1'b1;
            FLASH: begin
                ns = m_blink ? 3'b001 : 3'b000;
                ew = m_blink ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
        return {ns, ew, w, m_pend};
    endfunction

    task automatic cyc(input bit en, input bit ped, input bit fl);
        enable = en; ped_req = ped; flash_req = fl;
        @(posedge clock);
        m_step(en, ped, fl);
        #1;
        chk("model_outputs", 32'({light_ns, light_ew, walk, ped_wait}), 32'(m_out()));
        chk("model_phase", 32'(phase), 32'(m_st));
    endtask

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamp_t;
    lamp_t q[$];

    task automatic push(input logic [2:0] ns, input logic [2:0] ew, input int n);
        lamp_t e;
        e.ns = ns; e.ew = ew;
        repeat (n) q.push_back(e);
    endtask

    typedef struct packed {
        logic       en;
        logic [2:0] ns;
        logic [2:0] ew;
    } row_t;
    row_t tbl[9];

    initial begin
        int n, r, g;
        bit fl_r;
        lamp_t e;
        logic [7:0] snap;

        tbl[0] = '{1'b1, 3'b010, 3'b100};
        tbl[1] = '{1'b1, 3'b001, 3'b100};
        tbl[2] = '{1'b0, 3'b001, 3'b100};
        tbl[3] = '{1'b1, 3'b100, 3'b100};
        tbl[4] = '{1'b1, 3'b100, 3'b010};
        tbl[5] = '{1'b1, 3'b100, 3'b001};
        tbl[6] = '{1'b1, 3'b100, 3'b100};
        tbl[7] = '{1'b1, 3'b010, 3'b100};
        tbl[8] = '{1'b1, 3'b001, 3'b100};

        enable = 1'b1; ped_req = 1'b0; flash_req = 1'b0; en2 = 1'b1;
        rst_n = 1'b1; rst2_n = 1'b1;
        #1 rst_n = 1'b0; rst2_n = 1'b0;
        #1;
        chk("reset_outputs", 32'({light_ns, light_ew, walk, ped_wait}), 32'({3'b100, 3'b100, 1'b0, 1'b0}));
        chk("reset_phase", 32'(phase), 32'(AR_EW));
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        m_reset();

        // Default cycle from reset release.
        push(3'b100, 3'b100, 2);  push(3'b010, 3'b100, 20); push(3'b001, 3'b100, 4);
        push(3'b100, 3'b100, 2);  push(3'b100, 3'b010, 20); push(3'b100, 3'b001, 4);
        push(3'b100, 3'b100, 2);  push(3'b010, 3'b100, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            chk("default_seq", 32'({light_ns, light_ew}), 32'({e.ns, e.ew}));
            cyc(1, 0, 0);
        end

        // Pedestrian pulse during NS green.
        cyc(1, 1, 0);
        chk("ped_wait_set", 32'(ped_wait), 32'd1);
        n = 0;
        while (!walk && n < 100) begin cyc(1, 0, 0); n++; end
        chk("walk_reached", 32'(n < 100), 32'd1);
        chk("ped_wait_cleared", 32'(ped_wait), 32'd0);
        r = 0;
        while (walk && r < 50) begin
            chk("walk_lamps", 32'({light_ns, light_ew}), 32'({3'b100, 3'b100}));
            cyc(1, 0, 0); r++;
        end
        chk("walk_len", 32'(r), 32'(WK));
        chk("ew_after_walk", 32'(light_ew), 32'(3'b010));

        // Flash mode entered from NS green, then released.
        n = 0;
        while (phase != NS_G && n < 100) begin cyc(1, 0, 0); n++; end
        chk("reach_ns_g", 32'(n < 100), 32'd1);
        n = 0;
        while (phase != FLASH && n < 100) begin cyc(1, 0, 1); n++; end
        chk("reach_flash", 32'(n < 100), 32'd1);
        r = 0;
        while (light_ns == 3'b001 && r < 30) begin
            chk("flash_on_ew", 32'(light_ew), 32'(3'b100));
            cyc(1, 0, 1); r++;
        end
        chk("flash_on_len", 32'(r), 32'(FL));
        r = 0;
        while (light_ns == 3'b000 && r < 30) begin
            chk("flash_off_ew", 32'(light_ew), 32'(3'b000));
            cyc(1, 0, 1); r++;
        end
        chk("flash_off_len", 32'(r), 32'(FL));
        n = 0;
        while (phase == FLASH && n < 40) begin cyc(1, 0, 0); n++; end
        chk("flash_exit_len", 32'(n), 32'(FL));
        r = 0;
        while (light_ns == 3'b100 && light_ew == 3'b100 && r < 20) begin cyc(1, 0, 0); r++; end
        chk("flash_allred_len", 32'(r), 32'(AR));
        chk("ns_after_flash", 32'(light_ns), 32'(3'b010));

        // Enable dropped for 5 cycles in the middle of EW green.
        n = 0;
        while (phase != EW_G && n < 100) begin cyc(1, 0, 0); n++; end
        chk("reach_ew_g", 32'(n < 100), 32'd1);
        g = 0;
        while (light_ew == 3'b010 && g < 60) begin
            if (g == 7) begin
                snap = {light_ns, light_ew, walk, ped_wait};
                repeat (5) begin
                    cyc(0, 0, 0);
                    chk("frozen_outputs", 32'({light_ns, light_ew, walk, ped_wait}), 32'(snap));
                end
            end
            cyc(1, 0, 0); g++;
        end
        chk("ew_green_len", 32'(g), 32'(G));

        // Asynchronous reset mid WALK_EW with a request pending.
        cyc(1, 1, 0);
        n = 0;
        while (phase != WALK_EW && n < 100) begin cyc(1, 0, 0); n++; end
        chk("reach_walk_ew", 32'(n < 100), 32'd1);
        repeat (3) cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("ped_wait_in_walk", 32'({walk, ped_wait}), 32'({1'b1, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({light_ns, light_ew, walk, ped_wait}), 32'({3'b100, 3'b100, 1'b0, 1'b0}));
        chk("async_reset_phase", 32'(phase), 32'(AR_EW));
        m_reset();
        @(posedge clock);
        #1 rst_n = 1'b1;

        // Randomized run against the reference model.
        fl_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) fl_r = !fl_r;
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), fl_r);
        end

        // Short-dwell instance: every state one cycle, six-cycle period.
        enable = 1'b0;
        rst2_n = 1'b1;
        chk("p1_release", 32'({ns2, ew2, walk2, pw2}), 32'({3'b100, 3'b100, 1'b0, 1'b0}));
        for (int i = 0; i < 9; i++) begin
            en2 = tbl[i].en;
            @(posedge clock);
            #1;
            chk($sformatf("p1_row%0d", i), 32'({ns2, ew2, walk2}), 32'({tbl[i].ns, tbl[i].ew, 1'b0}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
